// File: rtl/sum_accum.sv
// Frame accumulator: sums len zero-extended samples, then holds the result until handshaken.
// Optional macro SUM_ACCUM_SAT_EN: saturate the accumulator instead of wrapping.
module sum_accum #(
  parameter int DATA_W = 2,
  parameter int ACC_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [LEN_W-1:0]  out_cnt,
  output logic              out_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     sum_ext;
  logic               carry;

  // One extra bit captures the carry out of the accumulator's MSB.
  assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(in_data);
  assign carry   = sum_ext[ACC_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          cnt_d = cnt_q + LEN_W'(1);
          rem_d = rem_q - LEN_W'(1);
          if (carry) begin
            ovf_d = 1'b1;
          end
`ifdef SUM_ACCUM_SAT_EN
          acc_d = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
          acc_d = sum_ext[ACC_W-1:0];
`endif
          if (rem_q == LEN_W'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // start is deliberately not looked at here, even in the handshake cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accum.sv
// Bench for sum_accum: a default instance and an ACC_W=4 instance share stimulus.
// Expected 4-bit overflow result depends on SUM_ACCUM_SAT_EN.
module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [1:0] in_data;
  logic       out_ready;

  logic       in_ready, out_valid, out_ovf, busy;
  logic [7:0] out_sum;
  logic [3:0] out_cnt;
  logic       in_ready_s, out_valid_s, out_ovf_s, busy_s;
  logic [3:0] out_sum_s;
  logic [3:0] out_cnt_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sum_accum dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cnt(out_cnt), .out_ovf(out_ovf), .busy(busy)
  );

  sum_accum #(.DATA_W(2), .ACC_W(4), .LEN_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
    .out_cnt(out_cnt_s), .out_ovf(out_ovf_s), .busy(busy_s)
  );

`ifdef SUM_ACCUM_SAT_EN
  localparam int SUM4_OVF = 15;
`else
  localparam int SUM4_OVF = 2;
`endif

  typedef struct packed {
    logic [3:0]      len;
    logic [5:0][1:0] beats;
    logic [3:0]      gap;
    logic [3:0]      stall;
    logic [7:0]      sum;
    logic [3:0]      cnt;
    logic            ovf;
    logic [3:0]      sum4;
    logic            ovf4;
  } vec_t;

  typedef struct packed {
    logic [7:0] sum;
    logic [3:0] cnt;
    logic       ovf;
    logic [3:0] sum4;
    logic       ovf4;
  } res_t;

  vec_t vecs [6];
  res_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int l, input int b0, input int b1, input int b2,
                         input int b3, input int b4, input int b5, input int gap, input int stall,
                         input int sum, input int cnt, input int ovf, input int sum4, input int ovf4);
    vec_t v;
    v.len = 4'(l);
    v.beats[0] = 2'(b0); v.beats[1] = 2'(b1); v.beats[2] = 2'(b2);
    v.beats[3] = 2'(b3); v.beats[4] = 2'(b4); v.beats[5] = 2'(b5);
    v.gap = 4'(gap); v.stall = 4'(stall);
    v.sum = 8'(sum); v.cnt = 4'(cnt); v.ovf = ovf[0];
    v.sum4 = 4'(sum4); v.ovf4 = ovf4[0];
    vecs[i] = v;
  endtask

  task automatic push_exp(input int sum, input int cnt, input int ovf, input int sum4, input int ovf4);
    res_t r;
    r.sum = 8'(sum); r.cnt = 4'(cnt); r.ovf = ovf[0]; r.sum4 = 4'(sum4); r.ovf4 = ovf4[0];
    sb.push_back(r);
  endtask

  task automatic start_frame(input int l);
    start = 1'b1;
    len   = 4'(l);
    step();
    start = 1'b0;
  endtask

  // Drives one beat after 'gap' idle cycles; 'run' is the sum expected before this beat.
  task automatic beat(input int d, input int gap, input int run);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      step();
      check("gap_sum_hold", out_sum, run);
    end
    in_valid = 1'b1;
    in_data  = 2'(d);
    check("in_ready_acc", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect(input int stall, input bit start_in_hs);
    res_t e;
    int   w;
    w = 0;
    while (!out_valid && w < 20) begin
      step();
      w++;
    end
    check("result_latency", w, 0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("out_sum", out_sum, e.sum);
    check("out_cnt", out_cnt, e.cnt);
    check("out_ovf", out_ovf, e.ovf);
    check("out_valid_s", out_valid_s, 1);
    check("out_sum_s", out_sum_s, e.sum4);
    check("out_ovf_s", out_ovf_s, e.ovf4);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      step();
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, e.sum);
      check("hold_cnt", out_cnt, e.cnt);
      check("hold_ovf", out_ovf, e.ovf);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    if (start_in_hs) begin
      start = 1'b1;
      len   = 4'd2;
    end
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_hs", {30'd0, out_valid, busy}, 0);
    check("idle_after_hs_s", {31'd0, busy_s}, 0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   run;
    v = vecs[i];
    push_exp(int'(v.sum), int'(v.cnt), int'(v.ovf), int'(v.sum4), int'(v.ovf4));
    start_frame(int'(v.len));
    check("frame_busy", busy, 1);
    check("frame_clear", {out_sum, out_cnt}, 0);
    run = 0;
    for (int b = 0; b < int'(v.len); b++) begin
      beat(int'(v.beats[b]), (b == 0) ? 0 : int'(v.gap), run);
      run += int'(v.beats[b]);
    end
    $display("vec %0d: len=%0d sum=%0d cnt=%0d ovf=%0d sum4=%0d ovf4=%0d",
             i, v.len, out_sum, out_cnt, out_ovf, out_sum_s, out_ovf_s);
    collect(int'(v.stall), 1'b0);
  endtask

  initial begin
    //        i len b0 b1 b2 b3 b4 b5 gap stall sum cnt ovf sum4      ovf4
    set_vec(0, 3, 1, 2, 3, 0, 0, 0, 0, 0,  6, 3, 0, 6,        0);
    set_vec(1, 2, 3, 3, 0, 0, 0, 0, 3, 0,  6, 2, 0, 6,        0);
    set_vec(2, 2, 2, 1, 0, 0, 0, 0, 0, 5,  3, 2, 0, 3,        0);
    set_vec(3, 6, 3, 3, 3, 3, 3, 3, 0, 0, 18, 6, 0, SUM4_OVF, 1);
    set_vec(4, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,        0);
    set_vec(5, 4, 3, 0, 3, 1, 0, 0, 1, 1,  7, 4, 0, 7,        0);

    rst_n = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs", {out_sum, out_cnt, out_ovf, out_valid, in_ready, busy}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(i);

    // start with len=0 is ignored
    start = 1'b1; len = 4'd0;
    step();
    start = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_in_ready", in_ready, 0);
    step();
    check("len0_still_idle", {out_valid, busy}, 0);
    $display("seq len0: busy=%0d out_valid=%0d", busy, out_valid);

    // start pulsed mid-frame and in the handshake cycle is ignored
    push_exp(3, 3, 0, 3, 0);
    start_frame(3);
    beat(1, 0, 0);
    start = 1'b1; len = 4'd5; in_valid = 1'b0;
    step();
    check("start_in_acc_cnt", out_cnt, 1);
    check("start_in_acc_sum", out_sum, 1);
    beat(1, 0, 1);
    start = 1'b0;
    beat(1, 0, 2);
    $display("seq start_in_acc: sum=%0d cnt=%0d", out_sum, out_cnt);
    collect(0, 1'b1);
    step();
    check("start_in_hs_ignored", busy, 0);

    // asynchronous reset mid-frame
    start_frame(4);
    beat(1, 0, 0);
    beat(1, 0, 1);
    check("pre_reset_cnt", out_cnt, 2);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {out_sum, out_cnt, out_ovf, out_valid, in_ready, busy}, 0);
    $display("seq async_reset: sum=%0d cnt=%0d busy=%0d", out_sum, out_cnt, busy);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("no_result_after_reset", {out_valid, busy}, 0);
    push_exp(2, 1, 0, 2, 0);
    start_frame(1);
    beat(2, 0, 0);
    $display("seq post_reset: sum=%0d cnt=%0d", out_sum, out_cnt);
    collect(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 SHALL have parameter DATA_W, default 2, width of each incoming sum sample.
REQ-002 SHALL have parameter ACC_W, default 8, accumulator and result width.
REQ-003 SHALL have parameter LEN_W, default 4, width of frame length and beat count.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port len  input  LEN_W  beats per frame, sampled with start.
REQ-008 SHALL have port in_valid  input  1  upstream sample valid.
REQ-009 SHALL have port in_data  input  DATA_W  sample from the registered adder output.
REQ-010 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-011 SHALL have port out_valid  output  1  frame result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_sum  output  ACC_W  accumulated frame sum.
REQ-014 SHALL have port out_cnt  output  LEN_W  beats accepted in frame.
REQ-015 SHALL have port out_ovf  output  1  overflow or saturation occurred in frame.
REQ-016 SHALL have port busy  output  1  high in ACC and HOLD.

Function
REQ-017 SHALL implement FSM states IDLE, ACC, HOLD; IDLE after reset.
REQ-018 SHALL, in IDLE, on start=1 with len!=0: clear acc, cnt and ovf, load remaining=len, go to ACC next cycle.
REQ-019 SHALL ignore start with len=0 (stay IDLE, no output activity).
REQ-020 SHALL drive in_ready=1 only in ACC; 0 in IDLE and HOLD.
REQ-021 SHALL accept a beat when in_valid and in_ready are both 1; in_valid=0 cycles leave all state unchanged.
REQ-022 SHALL, per accepted beat, add in_data zero-extended to ACC_W, increment cnt, and decrement remaining.
REQ-023 SHALL, on the beat that brings remaining to 0, enter HOLD; out_valid=1 on the following cycle with out_sum including that beat.
REQ-024 SHALL, in HOLD, hold out_sum, out_cnt and out_ovf stable until out_valid and out_ready are both 1, then go to IDLE.
REQ-025 SHALL ignore start in ACC and HOLD, including in the HOLD handshake cycle; start SHALL be re-presented in IDLE.
REQ-026 SHALL drive out_valid=0 in IDLE and ACC.
REQ-027 SHALL keep out_ovf sticky within a frame; cleared only on frame start or reset.

Reset
REQ-028 SHALL, on rst_n=0, immediately and regardless of clk, force state IDLE and out_sum=0, out_cnt=0, out_ovf=0, out_valid=0, in_ready=0, busy=0, remaining=0.
REQ-029 SHALL, on rst_n=0 mid-frame, discard the partial frame with no result emitted.

Configuration
REQ-030 SHALL use macro SUM_ACCUM_SAT_EN to select overflow handling.
REQ-031 SHALL, without SUM_ACCUM_SAT_EN, wrap the accumulator modulo 2^ACC_W and set out_ovf on any carry out of bit ACC_W-1.
REQ-032 SHALL, with SUM_ACCUM_SAT_EN, clamp the accumulator at 2^ACC_W-1, hold it there for later beats, and set out_ovf when clamping occurs.

Verification
REQ-033 SHALL cover: len=3, beats 1,2,3 back-to-back -> out_valid 1 cycle after 3rd beat, out_sum=6, out_cnt=3, out_ovf=0.
REQ-034 SHALL cover: len=2, in_valid gaps of 3 cycles between beats 3,3 -> out_sum=6, out_cnt=2; no accumulation in gap cycles.
REQ-035 SHALL cover: out_ready low for 5 cycles in HOLD -> outputs stable, in_ready=0; IDLE the cycle after the handshake.
REQ-036 SHALL cover: ACC_W=4, len=6, all beats 3 -> default: out_sum=2, out_ovf=1; SUM_ACCUM_SAT_EN: out_sum=15, out_ovf=1.
REQ-037 SHALL cover: start with len=0 -> stays IDLE; start pulsed during ACC -> no effect on acc, cnt or remaining.
REQ-038 SHALL cover: rst_n low after 2 of 4 beats -> all outputs 0 without waiting for clk; next start with len=1 and beat 2 -> out_sum=2.
